uart_word_loader: RTL
=====================

UART_WORD_LOADER -- requirements
Module: uart_word_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of the first word written.
REQ-002 The block SHALL have parameter MAX_WORDS, default 1024, giving the largest accepted payload word count.
REQ-003 Port i_Clock  input  1: single clock; all logic SHALL be rising-edge of i_Clock.
REQ-004 Port i_Reset  input  1: asynchronous, active-high reset.
REQ-005 Port i_Rx_DV  input  1: one-cycle strobe from the UART receiver, byte valid.
REQ-006 Port i_Rx_Byte  input  8: received byte, valid when i_Rx_DV=1.
REQ-007 Port o_wb_cyc  output  1: Wishbone cycle.
REQ-008 Port o_wb_stb  output  1: Wishbone strobe.
REQ-009 Port o_wb_we  output  1: Wishbone write enable.
REQ-010 Port o_wb_adr  output  32: Wishbone byte address.
REQ-011 Port o_wb_dat  output  32: Wishbone write data.
REQ-012 Port o_wb_sel  output  4: Wishbone byte select.
REQ-013 Port i_wb_ack  input  1: Wishbone acknowledge.
REQ-014 Port o_cpu_rst  output  1: CPU hold-in-reset, active-high.
REQ-015 Port o_done  output  1: load complete.
REQ-016 Port o_error  output  1: sticky fault (length too large or overflow).

Function
REQ-017 Byte assembly SHALL be little-endian: bytes 0..3 of a word map to bits [7:0], [15:8], [23:16], [31:24]; a 2-bit byte counter wraps 3->0 on each completed word.
REQ-018 The byte FSM SHALL have states S_LEN, S_DATA, S_DONE, S_ERR and SHALL leave reset in S_LEN.
REQ-019 S_LEN: the first completed word SHALL be latched as word count N. N=0 -> S_DONE. N>MAX_WORDS -> S_ERR. Otherwise -> S_DATA with word index=0.
REQ-020 S_DATA: each completed word SHALL be loaded into a one-word holding register with the pending flag set, its address = BASE_ADDR + 4*index, and index incremented; when index reaches N -> S_DONE.
REQ-021 The bus side SHALL drive o_wb_cyc=o_wb_stb=o_wb_we=1 and o_wb_sel=4'hF from the cycle after pending is set until the cycle i_wb_ack=1 is sampled; it SHALL then drop all three and clear pending in that same edge.
REQ-022 o_wb_adr/o_wb_dat SHALL be stable for the whole bus cycle; when idle they SHALL hold their last value and o_wb_sel SHALL be 4'h0.
REQ-023 Byte assembly SHALL continue during a pending bus write; a word completing while pending=1 and no ack in the same cycle SHALL be dropped, set o_error, and move the FSM to S_ERR.
REQ-024 A word completing in the same cycle that i_wb_ack=1 clears pending SHALL be accepted into the holding register (ack wins, no overflow).
REQ-025 S_DONE SHALL be entered only after the last word's ack (pending=0); o_done=1 and o_cpu_rst=0 in S_DONE; further i_Rx_DV bytes SHALL be ignored.
REQ-026 S_ERR SHALL ignore all bytes, keep o_cpu_rst=1, o_done=0, o_error=1, finish any in-flight bus cycle normally, and exit only on reset.
REQ-027 Word index and N SHALL be 16 bits; address arithmetic SHALL be 32-bit modulo 2^32.
REQ-028 Latency: o_wb_stb SHALL rise exactly 1 cycle after the i_Rx_DV that completes a data word (when no write is pending).

Reset
REQ-029 Asserting i_Reset at any time SHALL immediately force o_wb_cyc=0, o_wb_stb=0, o_wb_we=0, o_wb_sel=0, o_wb_adr=0, o_wb_dat=0, o_cpu_rst=1, o_done=0, o_error=0, FSM=S_LEN, byte counter=0, index=0, pending=0, aborting any bus cycle.
REQ-030 After reset deassertion, the first i_Rx_DV SHALL be treated as byte 0 of the length word.

Verification
REQ-031 Bytes 02 00 00 00, 78 56 34 12, EF BE AD DE with ack 1 cycle after stb -> writes 0x12345678 @BASE_ADDR, 0xDEADBEEF @BASE_ADDR+4; then o_done=1, o_cpu_rst=0.
REQ-032 Bytes 00 00 00 00 -> no bus cycle; o_done=1 one cycle after the 4th byte.
REQ-033 MAX_WORDS=4, bytes 05 00 00 00 -> o_error=1, o_cpu_rst=1, no bus cycle, later bytes ignored.
REQ-034 N=2, ack held low; second word completes while first is pending -> o_error=1, S_ERR; then ack -> first write completes, no second write.
REQ-035 N=2, second word completes in the cycle of first ack -> no error; both writes occur in order.
REQ-036 Reset asserted mid-bus-cycle after 1 of 3 words -> outputs at reset values; a new length word restarts writing at BASE_ADDR.

Source files
------------

// File: rtl/uart_word_loader.sv
// ---------------------------------------------------------------------------
// uart_word_loader
//
// Boot loader that turns a UART byte stream into Wishbone word writes.
// The first 32-bit little-endian word received is the payload length N
// (in words); the next N words are written to consecutive word addresses
// starting at BASE_ADDR. The CPU is held in reset until every write has
// been acknowledged. A length above MAX_WORDS, or a word arriving while
// the previous write is still waiting for its ack, is a sticky fault.
//
// Ports
//   i_Clock    : system clock, rising edge
//   i_Reset    : asynchronous active-high reset
//   i_Rx_DV    : one-cycle byte-valid strobe from the UART receiver
//   i_Rx_Byte  : received byte, valid with i_Rx_DV
//   o_wb_cyc   : Wishbone cycle
//   o_wb_stb   : Wishbone strobe
//   o_wb_we    : Wishbone write enable (writes only)
//   o_wb_adr   : Wishbone byte address
//   o_wb_dat   : Wishbone write data
//   o_wb_sel   : Wishbone byte select (4'hF during a write, 4'h0 when idle)
//   i_wb_ack   : Wishbone acknowledge
//   o_cpu_rst  : CPU hold-in-reset, released only once the load completes
//   o_done     : load complete
//   o_error    : sticky fault (length too large or write overflow)
//
// State  | meaning
// -------+---------------------------------------------------------------
// S_LEN  | assembling the length word
// S_DATA | assembling payload words and handing them to the bus
// S_DONE | all words written and acknowledged, CPU released, bytes ignored
// S_ERR  | fault seen, bytes ignored, in-flight write still completes
// ---------------------------------------------------------------------------
module uart_word_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    output logic        o_cpu_rst,
    output logic        o_done,
    output logic        o_error
);

    localparam logic [1:0] S_LEN  = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

    logic [1:0]  state;
    logic [1:0]  byte_cnt;
    logic [23:0] byte_buf;
    logic [15:0] word_cnt;
    logic [15:0] word_idx;
    logic        pending;

    logic        rx_take;
    logic        word_done;
    logic [31:0] rx_word;
    logic        bus_ack;
    logic        slot_free;
    logic        data_word;
    logic        load_word;
    logic        overflow;

    // Bytes only matter while a length or payload word is being collected.
    assign rx_take   = i_Rx_DV && ((state == S_LEN) || (state == S_DATA));
    assign word_done = rx_take && (byte_cnt == 2'd3);
    assign rx_word   = {i_Rx_Byte, byte_buf};

    // An ack retiring the held word frees the slot in the same edge, so a
    // word completing alongside the ack is taken rather than flagged.
    assign bus_ack   = pending && i_wb_ack;
    assign slot_free = !pending || bus_ack;

    // Words past the N-th (before the last ack lands) are not payload.
    assign data_word = word_done && (state == S_DATA) && (word_idx != word_cnt);
    assign load_word = data_word && slot_free;
    assign overflow  = data_word && !slot_free;

    // The bus cycle is exactly the life of the holding register.
    assign o_wb_cyc  = pending;
    assign o_wb_stb  = pending;
    assign o_wb_we   = pending;
    assign o_wb_sel  = pending ? 4'hF : 4'h0;

    assign o_done    = (state == S_DONE);
    assign o_cpu_rst = (state != S_DONE);
    assign o_error   = (state == S_ERR);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state    <= S_LEN;
            byte_cnt <= 2'd0;
            byte_buf <= 24'd0;
            word_cnt <= 16'd0;
            word_idx <= 16'd0;
            pending  <= 1'b0;
            o_wb_adr <= 32'd0;
            o_wb_dat <= 32'd0;
        end else begin
            if (rx_take) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    byte_buf[7:0]   <= i_Rx_Byte;
                    2'd1:    byte_buf[15:8]  <= i_Rx_Byte;
                    2'd2:    byte_buf[23:16] <= i_Rx_Byte;
                    default: ;
                endcase
            end

            if (load_word) begin
                pending  <= 1'b1;
                o_wb_adr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                o_wb_dat <= rx_word;
                word_idx <= word_idx + 16'd1;
            end else if (bus_ack) begin
                pending  <= 1'b0;
            end

            case (state)
                S_LEN: begin
                    if (word_done) begin
                        word_cnt <= rx_word[15:0];
                        word_idx <= 16'd0;
                        if (rx_word == 32'd0) begin
                            state <= S_DONE;
                        end else if (rx_word > MAX_WORDS_W) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (overflow) begin
                        state <= S_ERR;
                    end else if ((word_idx == word_cnt) && slot_free) begin
                        state <= S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
